// File: rtl/reg_file16.sv
// reg_file16: general register file feeding the 16-bit ALU operands.
// Two combinational read ports (R, S), one write port for ALU write-back,
// and a 3-bit status register (N/Z/C) loaded from the ALU flags.
// BYPASS=1 forwards same-cycle write data to a matching read port so the
// ALU sees the new value before the clock edge.
module reg_file16 #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter bit BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              W_En,
    input  logic [ADDR_W-1:0] W_Addr,
    input  logic [DATA_W-1:0] W_Data,
    input  logic [ADDR_W-1:0] R_Addr,
    input  logic [ADDR_W-1:0] S_Addr,
    output logic [DATA_W-1:0] R,
    output logic [DATA_W-1:0] S,
    input  logic              F_Ld,
    input  logic              N_in,
    input  logic              Z_in,
    input  logic              C_in,
    output logic              N,
    output logic              Z,
    output logic              C
);

    localparam int DEPTH = 2 ** ADDR_W;

    // Flag reset value: a cleared datapath reads as "result was zero".
    localparam logic [2:0] FLAGS_RST = 3'b010;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [2:0]        flags_q;
    logic [2:0]        flags_d;

    // Next-state for the array: only the addressed entry changes when enabled.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (W_En) begin
            regs_d[W_Addr] = W_Data;
        end
    end

    // Next-state for the status register, independent of the write port.
    always_comb begin
        flags_d = flags_q;
        if (F_Ld) begin
            flags_d = {N_in, Z_in, C_in};
        end
    end

    // Array storage; async reset clears every entry and drops any pending write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Status storage; async reset forces N=0 Z=1 C=0 and drops any pending load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q <= FLAGS_RST;
        end else begin
            flags_q <= flags_d;
        end
    end

    // Read port R with optional forwarding; forwarding is suppressed during
    // reset so the array reads all zeros while reset is high.
    always_comb begin
        R = regs_q[R_Addr];
        if (BYPASS && W_En && !reset && (W_Addr == R_Addr)) begin
            R = W_Data;
        end
    end

    // Read port S, same forwarding rule as port R.
    always_comb begin
        S = regs_q[S_Addr];
        if (BYPASS && W_En && !reset && (W_Addr == S_Addr)) begin
            S = W_Data;
        end
    end

    assign N = flags_q[2];
    assign Z = flags_q[1];
    assign C = flags_q[0];

endmodule

// File: tb/tb_reg_file16.sv
// tb_reg_file16: drives one forwarding instance (BYPASS=1) and one
// non-forwarding instance (BYPASS=0) from the same stimulus. A driver pushes
// the expected outputs of both instances into a queue each cycle; a monitor
// on the falling edge pops and compares.
module tb_reg_file16;

    localparam int DW = 16;
    localparam int AW = 3;
    localparam int EW = 4 * DW + 6;

    logic          clk;
    logic          reset;
    logic          W_En;
    logic [AW-1:0] W_Addr;
    logic [DW-1:0] W_Data;
    logic [AW-1:0] R_Addr;
    logic [AW-1:0] S_Addr;
    logic          F_Ld;
    logic          N_in;
    logic          Z_in;
    logic          C_in;
    logic [DW-1:0] R1, S1, R0, S0;
    logic          N1, Z1, C1, N0, Z0, C0;

    reg_file16 #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(1'b1)) dut_byp (
        .clk(clk), .reset(reset), .W_En(W_En), .W_Addr(W_Addr), .W_Data(W_Data),
        .R_Addr(R_Addr), .S_Addr(S_Addr), .R(R1), .S(S1),
        .F_Ld(F_Ld), .N_in(N_in), .Z_in(Z_in), .C_in(C_in),
        .N(N1), .Z(Z1), .C(C1)
    );

    reg_file16 #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(1'b0)) dut_nob (
        .clk(clk), .reset(reset), .W_En(W_En), .W_Addr(W_Addr), .W_Data(W_Data),
        .R_Addr(R_Addr), .S_Addr(S_Addr), .R(R0), .S(S0),
        .F_Ld(F_Ld), .N_in(N_in), .Z_in(Z_in), .C_in(C_in),
        .N(N0), .Z(Z0), .C(C0)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [DW-1:0] mem [8];
    logic [2:0]    flg;

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q [$];
    int            tag_q [$];
    int            checks = 0;
    int            errors = 0;

    // Expected outputs of both instances for the inputs currently driven.
    task automatic push_exp(input int tag);
        logic [DW-1:0] r1, s1, r0, s0;
        logic [2:0]    f;
        if (reset) begin
            r1 = '0; s1 = '0; r0 = '0; s0 = '0;
            f  = 3'b010;
        end else begin
            r0 = mem[R_Addr];
            s0 = mem[S_Addr];
            r1 = (W_En && W_Addr == R_Addr) ? W_Data : r0;
            s1 = (W_En && W_Addr == S_Addr) ? W_Data : s0;
            f  = flg;
        end
        exp_q.push_back({r1, s1, r0, s0, f, f});
        tag_q.push_back(tag);
    endtask

    // Monitor: every falling edge, compare everything the driver expected.
    always @(negedge clk) begin
        logic [EW-1:0] e;
        logic [EW-1:0] got;
        int            t;
        while (exp_q.size() != 0) begin
            e   = exp_q.pop_front();
            t   = tag_q.pop_front();
            got = {R1, S1, R0, S0, N1, Z1, C1, N0, Z0, C0};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL tag%0d R1/S1/R0/S0/flags1/flags0 got %h %h %h %h %b %b required %h %h %h %h %b %b",
                         t, got[EW-1-:DW], got[EW-1-DW-:DW], got[EW-1-2*DW-:DW], got[EW-1-3*DW-:DW],
                         got[5:3], got[2:0],
                         e[EW-1-:DW], e[EW-1-DW-:DW], e[EW-1-2*DW-:DW], e[EW-1-3*DW-:DW],
                         e[5:3], e[2:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called just after a rising edge: drive, record expectation, take the edge.
    task automatic cycle(input int tag, input logic we, input logic [AW-1:0] wa,
                         input logic [DW-1:0] wd, input logic [AW-1:0] ra,
                         input logic [AW-1:0] sa, input logic fld,
                         input logic n, input logic z, input logic c);
        W_En = we; W_Addr = wa; W_Data = wd;
        R_Addr = ra; S_Addr = sa;
        F_Ld = fld; N_in = n; Z_in = z; C_in = c;
        push_exp(tag);
        @(posedge clk);
        if (we) mem[wa] = wd;
        if (fld) flg = {n, z, c};
        #1;
    endtask

    task automatic read(input int tag, input logic [AW-1:0] ra, input logic [AW-1:0] sa);
        cycle(tag, 1'b0, '0, '0, ra, sa, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Reset pulse entirely between two rising edges, with a write and a flag
    // load presented that must both be discarded.
    task automatic reset_pulse(input int tag, input logic [AW-1:0] ra, input logic [AW-1:0] sa);
        reset  = 1'b1;
        W_En   = 1'b1;
        W_Addr = ra;
        W_Data = DW'($urandom);
        R_Addr = ra;
        S_Addr = sa;
        F_Ld   = 1'b1;
        N_in   = 1'b1; Z_in = 1'b0; C_in = 1'b1;
        for (int i = 0; i < 8; i++) mem[i] = '0;
        flg = 3'b010;
        push_exp(tag);
        @(negedge clk);
        #2;
        reset = 1'b0;
        W_En  = 1'b0;
        F_Ld  = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [DW:0] y;
        reset = 1'b1; W_En = 1'b0; W_Addr = '0; W_Data = '0;
        R_Addr = '0; S_Addr = '0; F_Ld = 1'b0; N_in = 1'b0; Z_in = 1'b0; C_in = 1'b0;
        for (int i = 0; i < 8; i++) mem[i] = '0;
        flg = 3'b010;
        @(posedge clk);
        #1;
        reset_pulse(1, 3, 4);
        read(2, 0, 7);

        // Reset clears a written register immediately.
        cycle(10, 1'b1, 3, 16'hABCD, 3, 3, 1'b0, 1'b0, 1'b0, 1'b0);
        read(11, 3, 3);
        reset_pulse(12, 3, 3);
        read(13, 3, 3);

        // Write every register, including r0, then sweep both ports.
        for (int i = 0; i < 8; i++)
            cycle(20 + i, 1'b1, AW'(i), DW'(16'h1111 * i), AW'(i), AW'(7 - i), 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++)
            read(30 + i, AW'(i), AW'(7 - i));

        // Forwarding: new value before the edge on BYPASS=1 only.
        cycle(40, 1'b1, 5, 16'h0005, 0, 1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(41, 1'b1, 5, 16'h8000, 5, 5, 1'b0, 1'b0, 1'b0, 1'b0);
        read(42, 5, 5);

        // Write disable holds the register.
        cycle(50, 1'b1, 2, 16'h0022, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(51, 1'b0, 2, 16'hFFFF, 2, 2, 1'b0, 1'b0, 1'b0, 1'b0);
        read(52, 2, 2);

        // Flag load and hold.
        cycle(60, 1'b0, 0, 0, 0, 0, 1'b1, 1'b1, 1'b0, 1'b1);
        cycle(61, 1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        read(62, 0, 0);

        // Closed loop: r3 = r1 + r2 with flags from the sum.
        cycle(70, 1'b1, 1, 16'hFFFF, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(71, 1'b1, 2, 16'h0001, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        y = {1'b0, mem[1]} + {1'b0, mem[2]};
        cycle(72, 1'b1, 3, y[DW-1:0], 1, 2, 1'b1, y[DW-1], (y[DW-1:0] == '0), y[DW]);
        read(73, 3, 3);

        // Randomized traffic with occasional reset pulses.
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 39) == 0)
                reset_pulse(1000 + k, AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
            else
                cycle(1000 + k, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)),
                      DW'($urandom), AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending %0d required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
